// File: rtl/ball_collision_scheduler.sv
// N-ball pairwise collision resolver: snapshots all balls each frame, scans pairs i<j one per
// clock with a look-ahead distance test, swaps dominant-axis speeds and applies a per-pair cooldown.
module ball_collision_scheduler #(
  parameter int unsigned N_BALLS          = 4,
  parameter int unsigned W                = 11,
  parameter int unsigned DISTANCE_SQUARED = 1023,
  parameter int unsigned LOOKAHEAD_SHIFT  = 1,
  parameter int unsigned COOLDOWN_FRAMES  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic [N_BALLS*W-1:0] x,
  input  logic [N_BALLS*W-1:0] y,
  input  logic [N_BALLS*W-1:0] xspeed,
  input  logic [N_BALLS*W-1:0] yspeed,
  output logic [N_BALLS*W-1:0] new_xspeed,
  output logic [N_BALLS*W-1:0] new_yspeed,
  output logic [N_BALLS-1:0]   collided,
  output logic                 done,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned P  = N_BALLS * (N_BALLS - 1) / 2;
  localparam int unsigned IW = $clog2(N_BALLS);
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int unsigned LW = W + 2;
  localparam int unsigned DW = W + 3;
  localparam int unsigned SW = 2 * W + 5;

  localparam logic [SW-1:0] DSQ     = SW'(DISTANCE_SQUARED);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);
  localparam logic [IW-1:0] LAST_I  = IW'(N_BALLS - 2);
  localparam logic [IW-1:0] LAST_J  = IW'(N_BALLS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e state_q, state_d;

  logic signed [W-1:0] wx_q  [N_BALLS];
  logic signed [W-1:0] wy_q  [N_BALLS];
  logic signed [W-1:0] wvx_q [N_BALLS];
  logic signed [W-1:0] wvy_q [N_BALLS];
  logic [N_BALLS-1:0]  wcol_q;
  logic [CW-1:0]       cd_q  [P];
  logic [P-1:0]        blk_q;
  logic [IW-1:0]       i_q, j_q;
  logic [PW-1:0]       p_q;

  logic signed [LW-1:0] lax_i, lax_j, lay_i, lay_j;
  logic signed [DW-1:0] dx, dy;
  logic [DW-1:0]        adx, ady;
  logic [SW-1:0]        adx_w, ady_w, d2;
  logic                 hit, swap_x, last_pair;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (frame_start) state_d = StScan;
      StScan:  if (last_pair) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  // Pair evaluation reads the working arrays, so swaps from earlier pairs feed later ones.
  always_comb begin
    lax_i = LW'(wx_q[i_q]) + (LW'(wvx_q[i_q]) <<< LOOKAHEAD_SHIFT);
    lax_j = LW'(wx_q[j_q]) + (LW'(wvx_q[j_q]) <<< LOOKAHEAD_SHIFT);
    lay_i = LW'(wy_q[i_q]) + (LW'(wvy_q[i_q]) <<< LOOKAHEAD_SHIFT);
    lay_j = LW'(wy_q[j_q]) + (LW'(wvy_q[j_q]) <<< LOOKAHEAD_SHIFT);
    dx    = DW'(lax_j) - DW'(lax_i);
    dy    = DW'(lay_j) - DW'(lay_i);
    adx   = dx[DW-1] ? -dx : dx;
    ady   = dy[DW-1] ? -dy : dy;
    adx_w = SW'(adx);
    ady_w = SW'(ady);
    d2    = adx_w * adx_w + ady_w * ady_w;
    hit       = !blk_q[p_q] && (d2 <= DSQ);
    swap_x    = (adx >= ady);
    last_pair = (i_q == LAST_I) && (j_q == LAST_J);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_BALLS; k++) begin
        wx_q[k]  <= '0;
        wy_q[k]  <= '0;
        wvx_q[k] <= '0;
        wvy_q[k] <= '0;
      end
      for (int p = 0; p < P; p++) begin
        cd_q[p] <= '0;
      end
      blk_q      <= '0;
      wcol_q     <= '0;
      i_q        <= '0;
      j_q        <= '0;
      p_q        <= '0;
      new_xspeed <= '0;
      new_yspeed <= '0;
      collided   <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= frame_start && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            for (int k = 0; k < N_BALLS; k++) begin
              wx_q[k]  <= x[k*W +: W];
              wy_q[k]  <= y[k*W +: W];
              wvx_q[k] <= xspeed[k*W +: W];
              wvy_q[k] <= yspeed[k*W +: W];
            end
            // Blocking uses the pre-decrement count so a pair sits out exactly
            // COOLDOWN_FRAMES frames after a hit.
            for (int p = 0; p < P; p++) begin
              blk_q[p] <= (cd_q[p] != '0);
              if (cd_q[p] != '0) cd_q[p] <= cd_q[p] - CW'(1);
            end
            wcol_q <= '0;
            i_q    <= '0;
            j_q    <= IW'(1);
            p_q    <= '0;
          end
        end
        StScan: begin
          if (hit) begin
            if (swap_x) begin
              wvx_q[i_q] <= wvx_q[j_q];
              wvx_q[j_q] <= wvx_q[i_q];
            end else begin
              wvy_q[i_q] <= wvy_q[j_q];
              wvy_q[j_q] <= wvy_q[i_q];
            end
            wcol_q[i_q] <= 1'b1;
            wcol_q[j_q] <= 1'b1;
            cd_q[p_q]   <= CD_LOAD;
          end
          p_q <= p_q + PW'(1);
          if (j_q == LAST_J) begin
            i_q <= i_q + IW'(1);
            j_q <= i_q + IW'(2);
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        StDone: begin
          for (int k = 0; k < N_BALLS; k++) begin
            new_xspeed[k*W +: W] <= wvx_q[k];
            new_yspeed[k*W +: W] <= wvy_q[k];
          end
          collided <= wcol_q;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_collision_scheduler.sv
// Directed self-checking bench for ball_collision_scheduler (N=4, W=11, cooldown 5).
module tb_ball_collision_scheduler;

  localparam int N  = 4;
  localparam int W  = 11;
  localparam int NW = N * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic [NW-1:0] x = '0, y = '0, xspeed = '0, yspeed = '0;
  logic [NW-1:0] new_xspeed, new_yspeed;
  logic [N-1:0]  collided;
  logic          done, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  ball_collision_scheduler #(
    .N_BALLS         (4),
    .W               (11),
    .DISTANCE_SQUARED(1023),
    .LOOKAHEAD_SHIFT (1),
    .COOLDOWN_FRAMES (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .x          (x),
    .y          (y),
    .xspeed     (xspeed),
    .yspeed     (yspeed),
    .new_xspeed (new_xspeed),
    .new_yspeed (new_yspeed),
    .collided   (collided),
    .done       (done),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW-1:0] pack(input int a, input int b, input int c, input int d);
    logic [NW-1:0] v;
    v[0*W +: W] = W'(a);
    v[1*W +: W] = W'(b);
    v[2*W +: W] = W'(c);
    v[3*W +: W] = W'(d);
    return v;
  endfunction

  task automatic set_ball(input int k, input int px, input int py, input int vx, input int vy);
    x[k*W +: W]      = W'(px);
    y[k*W +: W]      = W'(py);
    xspeed[k*W +: W] = W'(vx);
    yspeed[k*W +: W] = W'(vy);
  endtask

  task automatic place_far;
    set_ball(2, -400, -400, 5, -3);
    set_ball(3, 400, 400, -7, 6);
  endtask

  task automatic setup_head_on;
    set_ball(0, 100, 100, 3, 0);
    set_ball(1, 130, 100, -2, 0);
    place_far();
  endtask

  task automatic do_reset;
    reset       = 1'b1;
    frame_start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Strobe frame_start and wait (bounded) for done; cyc counts edges after the strobe edge.
  task automatic run_frame(output int cyc);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++; if (new_xspeed !== '0) begin n_fail++; $display("FAIL reset_vx: got %h want 0", new_xspeed); end
    n_checks++; if (new_yspeed !== '0) begin n_fail++; $display("FAIL reset_vy: got %h want 0", new_yspeed); end
    n_checks++; if (collided !== '0) begin n_fail++; $display("FAIL reset_col: got %b want 0", collided); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
  endtask

  task automatic test_head_on;
    int cyc;
    do_reset();
    setup_head_on();
    run_frame(cyc);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL head_latency: got %0d want 7", cyc); end
    n_checks++; if (new_xspeed !== pack(-2, 3, 5, -7)) begin n_fail++; $display("FAIL head_vx: got %h want %h", new_xspeed, pack(-2, 3, 5, -7)); end
    n_checks++; if (new_yspeed !== pack(0, 0, -3, 6)) begin n_fail++; $display("FAIL head_vy: got %h want %h", new_yspeed, pack(0, 0, -3, 6)); end
    n_checks++; if (collided !== 4'b0011) begin n_fail++; $display("FAIL head_col: got %b want 0011", collided); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL head_busy_at_done: got %b want 0", busy); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL head_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_vertical;
    int cyc;
    do_reset();
    set_ball(0, 200, 100, 0, 2);
    set_ball(1, 205, 125, 1, -1);
    place_far();
    run_frame(cyc);
    n_checks++; if (new_xspeed !== pack(0, 1, 5, -7)) begin n_fail++; $display("FAIL vert_vx: got %h want %h", new_xspeed, pack(0, 1, 5, -7)); end
    n_checks++; if (new_yspeed !== pack(-1, 2, -3, 6)) begin n_fail++; $display("FAIL vert_vy: got %h want %h", new_yspeed, pack(-1, 2, -3, 6)); end
    n_checks++; if (collided !== 4'b0011) begin n_fail++; $display("FAIL vert_col: got %b want 0011", collided); end
  endtask

  task automatic test_threshold;
    int cyc;
    do_reset();
    set_ball(0, 0, 0, 0, 0);
    set_ball(1, 31, 0, 0, 0);
    place_far();
    run_frame(cyc);
    n_checks++; if (collided !== 4'b0011) begin n_fail++; $display("FAIL thr_961_col: got %b want 0011", collided); end
    do_reset();
    set_ball(1, 32, 0, 0, 0);
    run_frame(cyc);
    n_checks++; if (collided !== 4'b0000) begin n_fail++; $display("FAIL thr_1024_col: got %b want 0000", collided); end
    n_checks++; if (new_xspeed !== pack(0, 0, 5, -7)) begin n_fail++; $display("FAIL thr_1024_vx: got %h want %h", new_xspeed, pack(0, 0, 5, -7)); end
    n_checks++; if (new_yspeed !== pack(0, 0, -3, 6)) begin n_fail++; $display("FAIL thr_1024_vy: got %h want %h", new_yspeed, pack(0, 0, -3, 6)); end
  endtask

  task automatic test_cooldown;
    int            cyc;
    logic          exp_hit;
    logic [N-1:0]  exp_col;
    logic [NW-1:0] exp_vx;
    do_reset();
    setup_head_on();
    for (int f = 1; f <= 7; f++) begin
      run_frame(cyc);
      exp_hit = (f == 1) || (f == 7);
      exp_col = exp_hit ? 4'b0011 : 4'b0000;
      exp_vx  = exp_hit ? pack(-2, 3, 5, -7) : pack(3, -2, 5, -7);
      n_checks++; if (collided !== exp_col) begin n_fail++; $display("FAIL cool_col frame %0d: got %b want %b", f, collided, exp_col); end
      n_checks++; if (new_xspeed !== exp_vx) begin n_fail++; $display("FAIL cool_vx frame %0d: got %h want %h", f, new_xspeed, exp_vx); end
    end
  endtask

  task automatic test_chain;
    int cyc;
    do_reset();
    set_ball(0, 0, 0, 4, 0);
    set_ball(1, 20, 0, 0, 0);
    set_ball(2, 40, 0, 0, 0);
    set_ball(3, 400, 400, -7, 6);
    run_frame(cyc);
    n_checks++; if (new_xspeed !== pack(0, 0, 4, -7)) begin n_fail++; $display("FAIL chain_vx: got %h want %h", new_xspeed, pack(0, 0, 4, -7)); end
    n_checks++; if (new_yspeed !== pack(0, 0, 0, 6)) begin n_fail++; $display("FAIL chain_vy: got %h want %h", new_yspeed, pack(0, 0, 0, 6)); end
    n_checks++; if (collided !== 4'b0111) begin n_fail++; $display("FAIL chain_col: got %b want 0111", collided); end
  endtask

  task automatic test_overrun_reset;
    int   cyc;
    logic seen_done;
    do_reset();
    setup_head_on();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b want 1", busy); end
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
    tick();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle: got %b want 0", overrun); end
    cyc = 4;
    while (done !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL ovr_latency: got %0d want 7", cyc); end
    n_checks++; if (collided !== 4'b0011) begin n_fail++; $display("FAIL ovr_col: got %b want 0011", collided); end
    // Abort a scan with reset; pair (0,1) still has a live cooldown at this point.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (new_xspeed !== '0) begin n_fail++; $display("FAIL rst_vx: got %h want 0", new_xspeed); end
    n_checks++; if (collided !== '0) begin n_fail++; $display("FAIL rst_col: got %b want 0", collided); end
    seen_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got %b want 0", seen_done); end
    run_frame(cyc);
    n_checks++; if (collided !== 4'b0011) begin n_fail++; $display("FAIL rst_cd_cleared_col: got %b want 0011", collided); end
    n_checks++; if (new_xspeed !== pack(-2, 3, 5, -7)) begin n_fail++; $display("FAIL rst_cd_cleared_vx: got %h want %h", new_xspeed, pack(-2, 3, 5, -7)); end
  endtask

  initial begin
    test_reset();
    test_head_on();
    test_vertical();
    test_threshold();
    test_cooldown();
    test_chain();
    test_overrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_collision_scheduler.md
# ball_collision_scheduler

Parametrised N-ball successor to the two-ball collision checker. Once per frame it snapshots the positions and speeds of all balls. It scans every unordered pair (i<j) sequentially, one pair per clock, with a look-ahead distance test. Colliding pairs exchange velocity components along the dominant axis, and a per-pair cooldown suppresses repeat hits. It sits between the ball position registers and the friction stage, and runs on the system clock with a frame strobe.

## Interface
- N_BALLS, 4: number of balls, ≥2; P = N_BALLS*(N_BALLS-1)/2 pairs.
- W, 11: signed width of each position/speed component.
- DISTANCE_SQUARED, 1023: collision when look-ahead dx²+dy² ≤ this, unsigned compare.
- LOOKAHEAD_SHIFT, 1: look-ahead position = pos + (speed <<< LOOKAHEAD_SHIFT).
- COOLDOWN_FRAMES, 5: frames a pair is ignored after colliding; 0 disables.

Ports:
- clk, in, 1: system clock, all logic on posedge.
- reset, in, 1: synchronous, active-high.
- frame_start, in, 1: one-cycle strobe per frame (vsync edge).
- x, y, in, N_BALLS*W: packed signed positions, ball k at [k*W +: W].
- xspeed, yspeed, in, N_BALLS*W: packed signed speeds, same packing.
- new_xspeed, new_yspeed, out, N_BALLS*W: resolved speeds, held until next done.
- collided, out, N_BALLS: ball k took part in ≥1 collision this frame, held with speeds.
- done, out, 1: one-cycle pulse; outputs updated on the same edge.
- busy, out, 1: high from snapshot through done.
- overrun, out, 1: one-cycle pulse when frame_start arrives while busy.

## Operation
- FSM states: IDLE → SCAN → DONE → IDLE.
- IDLE: on frame_start, latch all inputs into working arrays and clear the working collided mask. Decrement every nonzero pair cooldown by 1. Set i=0, j=1 and go to SCAN.
- SCAN: each cycle evaluate pair (i,j) using the current working arrays, so updates from earlier pairs are visible to later pairs.
  - dx = (x_j + (vx_j<<<S)) − (x_i + (vx_i<<<S)), with operands sign-extended to W+2 bits; dy likewise.
  - d² = dx*dx + dy*dy, computed full width (2W+5 bits), no truncation.
  - Hit when d² ≤ DISTANCE_SQUARED and cooldown(i,j) == 0.
  - On hit with |dx| ≥ |dy|: swap vx_i and vx_j; vy unchanged.
  - On hit with |dx| < |dy|: swap vy_i and vy_j.
  - On hit: set working collided bits i and j; load cooldown(i,j) = COOLDOWN_FRAMES.
  - Pair order is lexicographic: (0,1),(0,2)…(0,N−1),(1,2)…(N−2,N−1). After the last pair go to DONE.
- DONE: copy working speeds and mask to the outputs, pulse done, return to IDLE.
- A swap cannot overflow; no saturation is applied.
- Cooldown storage: P counters of width clog2(COOLDOWN_FRAMES+1), indexed by pair number.

## Timing
- frame_start sampled at edge k in IDLE. Pairs are evaluated at edges k+1 … k+P. done is high and outputs update after edge k+P+1. busy is high from after edge k until after edge k+P+1.
- Latency from frame_start to done is P+1 cycles (7 for N=4). Minimum frame_start spacing is P+2 cycles.
- frame_start while busy: ignored, overrun pulses one cycle, the scan is not disturbed, and cooldowns are not decremented.
- Inputs may change after the snapshot edge without effect.
- Reset values: new_xspeed/new_yspeed = 0, collided = 0, done = 0, busy = 0, overrun = 0, all cooldowns = 0, state IDLE.
- Reset mid-SCAN aborts the scan: no done pulse, and the outputs are zeroed.

## Test plan
- Head-on x: N=4. Ball0 at (100,100) v(3,0); ball1 at (130,100) v(−2,0); balls 2 and 3 at ±400 apart. Required: dx=20, d²=400 → new v0=(−2,0), v1=(3,0), collided=4'b0011, done exactly 7 cycles after frame_start.
- Vertical: ball0 at (200,100) v(0,2); ball1 at (205,125) v(1,−1). Required: dx=7, dy=19 → y swap only, v0=(0,−1), v1=(1,2).
- Threshold: static balls with dx=31 (d²=961) → hit; dx=32 (d²=1024) → no hit; speeds pass through unchanged and collided=0.
- Cooldown: repeat the head-on positions every frame. Required: hit on frame 1, no hit on frames 2–6 (speeds pass through), hit again on frame 7.
- Chain: ball0 v(4,0) touching ball1 v(0,0), ball1 touching ball2 v(0,0) in a line on x. Required: pair (0,1) swaps first, then (1,2) sees vx1=4 → final vx = (0,0,4), collided=3'b111 plus ball3 clear.
- Overrun/reset: frame_start 3 cycles after a prior frame_start → overrun pulse, done still at cycle 7. Reset asserted at cycle 4 → busy=0, no done, outputs 0, next frame starts with all cooldowns 0.
